fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch against a single-outstanding, request/grant/response instruction memory port.
- Advances the PC by 4 per granted fetch.
- Accepts redirects (taken branch, jal, jalr targets already muxed by the next-PC select logic) and discards any in-flight fetch made stale by a redirect.
- Presents one fetched instruction at a time to decode through a valid/ready output register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (low 2 bits must be 0).
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when no instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  one-cycle pulse: control flow change.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0).
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; equals pc whenever imem_req=1.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response data valid; at least 1 cycle after gnt.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  if_instr/if_pc hold a live instruction.
- if_ready  input  1  decode accepts the instruction this cycle.
- if_pc  output  32  PC of the held instruction.
- if_pc_p_4  output  32  if_pc + 4, mod 2^32; feeds the fall-through input of next-PC select.
- if_instr  output  32  held instruction word.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=BOOT, pc=RESET_PC.
  - imem_req=0, if_valid=0, if_pc=RESET_PC, if_instr=NOP_INSTR.
- States:
  - BOOT: idle for 1 cycle after reset release, then FETCH. imem_req=0.
  - FETCH: imem_req = slot_free, where slot_free = !if_valid | if_ready.
    - On imem_req & imem_gnt: pc<=pc+4, go to WAIT.
    - With imem_req=0, stay in FETCH.
  - WAIT: imem_req=0.
    - On imem_rvalid: if_instr<=imem_rdata, if_pc<=pc-4 (the fetched address, captured as fetch_addr at grant), if_valid<=1, go to FETCH.
  - DRAIN: stale fetch outstanding, imem_req=0.
    - On imem_rvalid: discard the data, go to FETCH.
- Output slot:
  - Cleared when if_valid & if_ready, unless it is reloaded in the same cycle.
  - Holds its contents while if_valid & !if_ready.
- Single-outstanding rule: at most one granted-but-unanswered fetch. Because requests are gated by slot_free, a response never finds the slot occupied.
- Redirect has priority over every other event in the same cycle:
  - All states: pc<=redirect_pc & ~3, if_valid<=0, if_instr<=NOP_INSTR.
  - FETCH, no gnt this cycle: the request is withdrawn on the next cycle. imem_req may still be high in the redirect cycle, but the address is not granted. Stay in FETCH.
  - FETCH with imem_gnt in the same cycle: the old address is in flight. Go to DRAIN; pc is not incremented.
  - WAIT without rvalid: go to DRAIN.
  - WAIT with rvalid in the same cycle: drop the data, go to FETCH.
  - DRAIN without rvalid: stay in DRAIN. pc takes the newest redirect value.
  - DRAIN with rvalid: go to FETCH.
  - BOOT: pc<=target, go to FETCH.
- Back-to-back redirects: the last one wins. There is never more than one stale fetch.
- pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No exception is raised.
- if_pc_p_4 is combinational from if_pc.
- Asserting reset mid-operation abandons any outstanding fetch. The memory side must tolerate a response arriving after reset; that response is ignored because the state is BOOT or FETCH with nothing outstanding.
- Throughput: with 1-cycle memory latency and if_ready=1 continuously, one instruction is delivered every 2 cycles.

Test Plan:
- Reset release, gnt=1 always, rvalid 1 cycle after gnt, if_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - if_pc sequence 0x0, 0x4, 0x8 with matching if_instr.
  - if_pc_p_4 = if_pc + 4.
- Backpressure: hold if_ready=0 after the first instruction lands:
  - if_valid stays 1, if_pc stays 0x0, imem_req stays 0.
  - Raise if_ready: a request for 0x4 is issued in that same cycle.
- Redirect in WAIT (fetch of 0x8 outstanding), redirect_pc=0x100:
  - The response for 0x8 is discarded (if_valid stays 0).
  - The next imem_addr is 0x100, and if_pc becomes 0x100.
- Redirect coincident with imem_gnt for 0x10, redirect_pc=0x203:
  - The block enters DRAIN and discards the 0x10 response.
  - The next fetch address is 0x200.
- Redirect coincident with imem_rvalid in WAIT: the data is dropped, and a fetch of the target is issued on the next cycle.
- Wrap-around and reset:
  - With pc=0xFFFF_FFFC, the fetch after it is 0x0.
  - Assert rst_n=0 mid-WAIT: the outputs immediately take their reset values, and a late rvalid produces no if_valid.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Owns the architectural PC. It fetches instructions through a memory port
// that uses request, grant and response handshakes and allows only one
// outstanding fetch. Each fetched word is handed to decode through a
// valid/ready output register.
//
// Ports:
//   clk, rst_n       - clock; asynchronous active-low reset, released synchronously
//   redirect_valid   - one-cycle pulse that changes control flow to redirect_pc
//   redirect_pc      - redirect target; bits [1:0] are ignored
//   imem_req         - fetch request; when high, imem_addr equals pc
//   imem_addr        - fetch address
//   imem_gnt         - the memory accepted the request this cycle
//   imem_rvalid      - response valid; arrives at least one cycle after the grant
//   imem_rdata       - instruction word of the response
//   if_valid         - if_pc / if_instr hold a live instruction
//   if_ready         - decode takes the held instruction this cycle
//   if_pc            - PC of the held instruction
//   if_pc_p_4        - if_pc + 4; the fall-through input of the next-PC select logic
//   if_instr         - held instruction word; NOP_INSTR when the slot is empty

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_p_4,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3   // a fetch made stale by a redirect is still outstanding
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] fetch_addr_reg;
  logic        if_valid_reg;
  logic [31:0] if_pc_reg;
  logic [31:0] if_instr_reg;

  logic        slot_free;
  logic        granted;
  logic [31:0] redirect_target;

  // A request is only raised when the output slot is empty or is being
  // emptied this cycle. So a response never finds the slot occupied, and no
  // skid buffer is needed.
  assign slot_free       = !if_valid_reg || if_ready;
  assign imem_req        = (state_reg == ST_FETCH) && slot_free;
  assign imem_addr       = pc_reg;
  assign granted         = imem_req && imem_gnt;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign if_valid  = if_valid_reg;
  assign if_pc     = if_pc_reg;
  assign if_pc_p_4 = if_pc_reg + 32'd4;
  assign if_instr  = if_instr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_BOOT;
      pc_reg         <= RESET_PC;
      fetch_addr_reg <= RESET_PC;
      if_valid_reg   <= 1'b0;
      if_pc_reg      <= RESET_PC;
      if_instr_reg   <= NOP_INSTR;
    end else begin
      // Decode consumed the held instruction. A reload later in this block
      // takes priority over this clear.
      if (if_valid_reg && if_ready) begin
        if_valid_reg <= 1'b0;
        if_instr_reg <= NOP_INSTR;
      end

      if (redirect_valid) begin
        // A redirect overrides every other event in this cycle. If a fetch
        // is still in flight, DRAIN swallows its response. pc is not advanced
        // even when the old address is granted in this cycle.
        pc_reg       <= redirect_target;
        if_valid_reg <= 1'b0;
        if_instr_reg <= NOP_INSTR;
        unique case (state_reg)
          ST_BOOT:  state_reg <= ST_FETCH;
          ST_FETCH: state_reg <= granted ? ST_DRAIN : ST_FETCH;
          ST_WAIT:  state_reg <= imem_rvalid ? ST_FETCH : ST_DRAIN;
          ST_DRAIN: state_reg <= imem_rvalid ? ST_FETCH : ST_DRAIN;
          default:  state_reg <= ST_BOOT;
        endcase
      end else begin
        unique case (state_reg)
          ST_BOOT: begin
            state_reg <= ST_FETCH;
          end
          ST_FETCH: begin
            if (granted) begin
              fetch_addr_reg <= pc_reg;
              pc_reg         <= pc_reg + 32'd4;  // wraps modulo 2^32
              state_reg      <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (imem_rvalid) begin
              if_instr_reg <= imem_rdata;
              if_pc_reg    <= fetch_addr_reg;
              if_valid_reg <= 1'b1;
              state_reg    <= ST_FETCH;
            end
          end
          ST_DRAIN: begin
            if (imem_rvalid) begin
              state_reg <= ST_FETCH;
            end
          end
          default: begin
            state_reg <= ST_BOOT;
          end
        endcase
      end
    end
  end

endmodule
